config_serial_loader: RTL

- Upstream front-end for the configuration shift register.
- Receives an external SPI-mode-0 style frame (sclk/mosi/csN from chip pins) asynchronous to clk, synchronizes it, and drives serialEn/serialIn one bit per sclk rising edge.
- Returns the register's serialOut on miso for readback.
- Validates the frame length at csN deassertion and reports done or error.

---
 rtl/config_serial_loader.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/config_serial_loader.sv
// config_serial_loader: SPI-mode-0 front-end that streams a frame into the config shift register
//
// Ports:
//    clk        system clock
//    resetN     asynchronous active-low reset
//    spiSclk    external serial clock (asynchronous pin)
//    spiMosi    external serial data, MSB first (asynchronous pin)
//    spiCsN     external frame select, active-low (asynchronous pin)
//    spiMiso    readback bit presented to the pin
//    serialEn   one-cycle shift strobe to the config shift register
//    serialIn   bit to shift, valid while serialEn is high
//    serialOut  MSB of the config shift register
//    busy       high while a frame is in progress
//    loadDone   one-cycle pulse, frame had exactly ShiftRegSize bits
//    loadError  one-cycle pulse, wrong bit count (or timeout)
//
// Optional macro CONFIG_LOADER_TIMEOUT_EN adds an idle-sclk abort after
// TimeoutCycles clocks, followed by a WAIT_CS state until csN rises.
module config_serial_loader #(
   parameter int ShiftRegSize  = 17,
   parameter int SyncStages    = 2,
   parameter int TimeoutCycles = 4096
) (
   input  logic clk,
   input  logic resetN,
   input  logic spiSclk,
   input  logic spiMosi,
   input  logic spiCsN,
   output logic spiMiso,
   output logic serialEn,
   output logic serialIn,
   input  logic serialOut,
   output logic busy,
   output logic loadDone,
   output logic loadError
);
   localparam int CntW = $clog2(ShiftRegSize + 2);

   if (SyncStages < 2 || TimeoutCycles < 2) begin : g_bad_param
      $error("config_serial_loader: SyncStages and TimeoutCycles must be >= 2");
   end

`ifdef CONFIG_LOADER_TIMEOUT_EN
   localparam int TW = $clog2(TimeoutCycles + 1);
   typedef enum logic [1:0] {IDLE, SHIFT, WAIT_CS} state_e;
   logic [TW-1:0] to_cnt_q;
`else
   typedef enum logic [1:0] {IDLE, SHIFT} state_e;
`endif

   logic [SyncStages-1:0] sclk_sync_q, mosi_sync_q, csn_sync_q;
   logic [SyncStages:0]   vld_q;
   logic                  sclk_prev_q, csn_prev_q, armed_q;
   state_e                state_q;
   logic [CntW-1:0]       bit_cnt_q;
   logic                  busy_q, miso_q, en_q, sin_q, done_q, err_q;
   logic                  sclk_s, csn_s, sclk_rise, sclk_fall, csn_rise, csn_fall;

   assign sclk_s    = sclk_sync_q[SyncStages-1];
   assign csn_s     = csn_sync_q[SyncStages-1];
   assign sclk_rise = sclk_s & ~sclk_prev_q;
   assign sclk_fall = ~sclk_s & sclk_prev_q;
   assign csn_rise  = csn_s & ~csn_prev_q;
   // armed_q blocks a csN that was already low across reset release from starting a frame
   assign csn_fall  = armed_q & ~csn_s & csn_prev_q;

   always_ff @(posedge clk or negedge resetN)
      if (!resetN) begin
         sclk_sync_q <= '0;
         mosi_sync_q <= '0;
         csn_sync_q  <= '1;
         sclk_prev_q <= 1'b0;
         csn_prev_q  <= 1'b1;
         vld_q       <= '0;
         armed_q     <= 1'b0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SyncStages-2:0], spiSclk};
         mosi_sync_q <= {mosi_sync_q[SyncStages-2:0], spiMosi};
         csn_sync_q  <= {csn_sync_q[SyncStages-2:0], spiCsN};
         sclk_prev_q <= sclk_s;
         csn_prev_q  <= csn_s;
         vld_q       <= {vld_q[SyncStages-1:0], 1'b1};
         // vld_q full means csn_s/csn_prev_q carry real pin samples, not reset values
         armed_q     <= armed_q | (vld_q[SyncStages] & csn_s & csn_prev_q);
      end

   always_ff @(posedge clk or negedge resetN)
      if (!resetN) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         busy_q    <= 1'b0;
         miso_q    <= 1'b0;
         en_q      <= 1'b0;
         sin_q     <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
`ifdef CONFIG_LOADER_TIMEOUT_EN
         to_cnt_q  <= '0;
`endif
      end else begin
         en_q   <= 1'b0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            IDLE:
               if (csn_fall) begin
                  state_q   <= SHIFT;
                  bit_cnt_q <= '0;
                  busy_q    <= 1'b1;
                  miso_q    <= serialOut;
`ifdef CONFIG_LOADER_TIMEOUT_EN
                  to_cnt_q  <= '0;
`endif
               end
            SHIFT: begin
`ifdef CONFIG_LOADER_TIMEOUT_EN
               to_cnt_q <= (sclk_rise || sclk_fall) ? '0 : to_cnt_q + TW'(1);
`endif
               if (csn_rise) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= (bit_cnt_q == CntW'(ShiftRegSize));
                  err_q   <= (bit_cnt_q != CntW'(ShiftRegSize));
               end else if (sclk_rise) begin
                  en_q      <= 1'b1;
                  sin_q     <= mosi_sync_q[SyncStages-1];
                  bit_cnt_q <= (bit_cnt_q == CntW'(ShiftRegSize + 1)) ? bit_cnt_q : bit_cnt_q + CntW'(1);
               end else if (sclk_fall)
                  miso_q <= serialOut;
`ifdef CONFIG_LOADER_TIMEOUT_EN
               else if (to_cnt_q == TW'(TimeoutCycles - 1)) begin
                  state_q <= WAIT_CS;
                  busy_q  <= 1'b0;
                  err_q   <= 1'b1;
               end
`endif
            end
`ifdef CONFIG_LOADER_TIMEOUT_EN
            WAIT_CS:
               if (csn_rise) state_q <= IDLE;
`endif
            default: state_q <= IDLE;
         endcase
      end

   assign spiMiso   = miso_q;
   assign serialEn  = en_q;
   assign serialIn  = sin_q;
   assign busy      = busy_q;
   assign loadDone  = done_q;
   assign loadError = err_q;
endmodule
